// File: rtl/atm_keypad_requester_pkg.sv
// Definitions shared between the ATM keypad requester and the ATM core:
// operation codes, key codes, requester state encodings and the request record.
package atm_keypad_requester_pkg;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  typedef enum logic [2:0] {
    OP_NONE       = 3'd0,
    OP_BALANCE    = 3'd1,
    OP_WITHDRAW   = 3'd2,
    OP_DEPOSIT    = 3'd3,
    OP_CHANGE_PIN = 3'd4
  } op_e;

  localparam logic [3:0] KEY_ENTER  = 4'd10;
  localparam logic [3:0] KEY_CANCEL = 4'd11;
  localparam logic [3:0] KEY_CLEAR  = 4'd12;

  // Entry states come first so "state <= ST_NEWPIN" means "still collecting keys".
  typedef enum logic [2:0] {
    ST_IDLE_ACC = 3'd0,
    ST_PIN      = 3'd1,
    ST_OP       = 3'd2,
    ST_AMOUNT   = 3'd3,
    ST_NEWPIN   = 3'd4,
    ST_SEND     = 3'd5,
    ST_WAIT_RSP = 3'd6,
    ST_RESULT   = 3'd7
  } req_state_e;

  typedef struct packed {
    op_e         op;
    logic [3:0]  acc;
    logic [15:0] pin;
    logic [15:0] new_pin;
    logic [31:0] amount;
  } atm_req_t;

  function automatic logic is_digit(input logic [3:0] k);
    return k <= 4'd9;
  endfunction

endpackage

// File: rtl/atm_digit_accumulator.sv
// Shared digit entry register: BCD shift for PINs, decimal multiply-add for amounts.
// Digits beyond the mode's limit are dropped; clr has priority over a digit.
module atm_digit_accumulator
  import atm_keypad_requester_pkg::*;
#(
  parameter int AMT_DIGITS = 8,
  localparam int CW = $clog2(((AMT_DIGITS > 4) ? AMT_DIGITS : 4) + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  input  logic          dec_mode,
  input  logic [3:0]    digit,
  output logic [31:0]   value,
  output logic [CW-1:0] count
);

  logic [CW-1:0] limit;
  assign limit = dec_mode ? CW'(AMT_DIGITS) : CW'(4);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      value <= '0;
      count <= '0;
    end else if (clr) begin
      value <= '0;
      count <= '0;
    end else if (en && (count < limit)) begin
      value <= dec_mode ? (value * 32'd10 + {28'd0, digit})
                        : {16'd0, value[11:0], digit};
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/atm_keypad_requester.sv
// Keypad-side initiator for the ATM core: assembles a request from key strobes,
// issues it over valid/ready, then waits (bounded) for the core's response.
module atm_keypad_requester
  import atm_keypad_requester_pkg::*;
#(
  parameter int RSP_TIMEOUT = 1000,
  parameter int AMT_DIGITS  = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  output logic        req_valid,
  input  logic        req_ready,
  output logic [2:0]  req_operation,
  output logic [3:0]  req_acc_num,
  output logic [15:0] req_pin,
  output logic [15:0] req_new_pin,
  output logic [31:0] req_amount,
  input  logic        rsp_valid,
  input  logic        rsp_success,
  input  logic [31:0] rsp_balance,
  output logic        result_valid,
  output logic        result_success,
  output logic [31:0] result_balance,
  output logic        timeout_err,
  output logic        busy
);

  localparam int CW = $clog2(((AMT_DIGITS > 4) ? AMT_DIGITS : 4) + 1);
  localparam int TW = $clog2(RSP_TIMEOUT + 1);

  req_state_e    state, state_nx;
  atm_req_t      req_q;
  logic [TW-1:0] timer;
  logic [31:0]   acc_val;
  logic [CW-1:0] acc_cnt;

  logic k_dig, k_ent, k_can, k_clr;
  logic acc_en, acc_clr, ld_acc, ld_pin, ld_new, ld_amt, ld_op, fld_clr;
  logic hs, rsp_take, to_hit;
  op_e  op_nx;

  assign k_dig = key_valid && is_digit(key_code);
  assign k_ent = key_valid && (key_code == KEY_ENTER);
  assign k_can = key_valid && (key_code == KEY_CANCEL);
  assign k_clr = key_valid && (key_code == KEY_CLEAR);

  atm_digit_accumulator #(.AMT_DIGITS(AMT_DIGITS)) u_acc (
    .clk      (clk),
    .rst      (rst),
    .clr      (acc_clr),
    .en       (acc_en),
    .dec_mode (state == ST_AMOUNT),
    .digit    (key_code),
    .value    (acc_val),
    .count    (acc_cnt)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE_ACC;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    acc_en   = FALSE;
    acc_clr  = FALSE;
    ld_acc   = FALSE;
    ld_pin   = FALSE;
    ld_new   = FALSE;
    ld_amt   = FALSE;
    ld_op    = FALSE;
    op_nx    = req_q.op;
    fld_clr  = FALSE;
    hs       = FALSE;
    rsp_take = FALSE;
    to_hit   = FALSE;
    case (state)
      ST_IDLE_ACC: if (k_dig) begin
        ld_acc   = TRUE;
        state_nx = ST_PIN;
      end
      ST_PIN, ST_NEWPIN: begin
        if (k_clr) acc_clr = TRUE;
        else if (k_ent && (acc_cnt == CW'(4))) begin
          ld_pin   = (state == ST_PIN);
          ld_new   = (state == ST_NEWPIN);
          state_nx = (state == ST_PIN) ? ST_OP : ST_SEND;
        end else if (k_dig) acc_en = TRUE;
      end
      ST_OP: if (k_dig) begin
        case (key_code)
          4'd1: begin op_nx = OP_BALANCE;    ld_op = TRUE; state_nx = ST_SEND;   end
          4'd2: begin op_nx = OP_WITHDRAW;   ld_op = TRUE; state_nx = ST_AMOUNT; end
          4'd3: begin op_nx = OP_DEPOSIT;    ld_op = TRUE; state_nx = ST_AMOUNT; end
          4'd4: begin op_nx = OP_CHANGE_PIN; ld_op = TRUE; state_nx = ST_NEWPIN; end
          4'd5: begin fld_clr = TRUE; state_nx = ST_IDLE_ACC; end
          default: ;
        endcase
      end
      ST_AMOUNT: begin
        if (k_clr) acc_clr = TRUE;
        else if (k_ent && (acc_val != 32'd0)) begin
          ld_amt   = TRUE;
          state_nx = ST_SEND;
        end else if (k_dig) acc_en = TRUE;
      end
      ST_SEND: if (req_ready) begin
        hs       = TRUE;
        state_nx = ST_WAIT_RSP;
      end
      ST_WAIT_RSP: begin
        // A response landing on the last allowed cycle beats the timeout.
        if (rsp_valid) begin
          rsp_take = TRUE;
          state_nx = ST_RESULT;
        end else if (timer == TW'(RSP_TIMEOUT - 1)) begin
          to_hit   = TRUE;
          state_nx = ST_RESULT;
        end
      end
      ST_RESULT: begin
        fld_clr  = TRUE;
        state_nx = ST_IDLE_ACC;
      end
      default: state_nx = ST_IDLE_ACC;
    endcase
    if (k_can && (state <= ST_NEWPIN)) begin
      state_nx = ST_IDLE_ACC;
      fld_clr  = TRUE;
      acc_en   = FALSE;
      ld_acc   = FALSE;
      ld_pin   = FALSE;
      ld_new   = FALSE;
      ld_amt   = FALSE;
      ld_op    = FALSE;
    end
    // Every state change starts the next field with an empty accumulator.
    acc_clr = acc_clr || (state_nx != state);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_q          <= '0;
      timer          <= '0;
      result_success <= FALSE;
      result_balance <= '0;
      timeout_err    <= FALSE;
    end else begin
      if (fld_clr) req_q         <= '0;
      if (ld_acc)  req_q.acc     <= key_code;
      if (ld_pin)  req_q.pin     <= acc_val[15:0];
      if (ld_new)  req_q.new_pin <= acc_val[15:0];
      if (ld_amt)  req_q.amount  <= acc_val;
      if (ld_op)   req_q.op      <= op_nx;
      if (hs) begin
        timer       <= '0;
        timeout_err <= FALSE;
      end else if (state == ST_WAIT_RSP) begin
        timer <= timer + TW'(1);
      end
      if (rsp_take) begin
        result_success <= rsp_success;
        result_balance <= rsp_balance;
      end
      if (to_hit) begin
        timeout_err    <= TRUE;
        result_success <= FALSE;
      end
    end
  end

  assign req_valid     = (state == ST_SEND);
  assign busy          = (state == ST_SEND) || (state == ST_WAIT_RSP);
  assign result_valid  = (state == ST_RESULT);
  assign req_operation = req_q.op;
  assign req_acc_num   = req_q.acc;
  assign req_pin       = req_q.pin;
  assign req_new_pin   = req_q.new_pin;
  assign req_amount    = req_q.amount;

endmodule

// File: tb/tb_atm_keypad_requester.sv
// Bench for atm_keypad_requester: directed scenarios plus random key/handshake
// traffic, checked every cycle against a transaction-level model.
module tb_atm_keypad_requester;

  localparam int TO = 50;
  localparam int AD = 8;

  logic        clk = 1'b0, rst = 1'b0;
  logic        key_valid = 1'b0, req_ready = 1'b0, rsp_valid = 1'b0, rsp_success = 1'b0;
  logic [3:0]  key_code = '0;
  logic [31:0] rsp_balance = '0;
  logic        req_valid, result_valid, result_success, timeout_err, busy;
  logic [2:0]  req_operation;
  logic [3:0]  req_acc_num;
  logic [15:0] req_pin, req_new_pin;
  logic [31:0] req_amount, result_balance;

  atm_keypad_requester #(.RSP_TIMEOUT(TO), .AMT_DIGITS(AD)) dut (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
    .req_valid(req_valid), .req_ready(req_ready), .req_operation(req_operation),
    .req_acc_num(req_acc_num), .req_pin(req_pin), .req_new_pin(req_new_pin),
    .req_amount(req_amount), .rsp_valid(rsp_valid), .rsp_success(rsp_success),
    .rsp_balance(rsp_balance), .result_valid(result_valid),
    .result_success(result_success), .result_balance(result_balance),
    .timeout_err(timeout_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;

  // Model: ph 0 account, 1 pin, 2 op, 3 amount, 4 new pin, 5 send, 6 wait, 7 result.
  int          ph;
  int          dq[$];
  int          wcnt;
  logic [31:0] m_acc, m_pin, m_new, m_amt, m_op, m_rb;
  logic        m_rs, m_to;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
    end
  endfunction

  function automatic logic [31:0] as_bcd();
    logic [31:0] v = 0;
    foreach (dq[i]) v = (v << 4) | 32'(dq[i]);
    return v;
  endfunction

  function automatic logic [31:0] as_dec();
    logic [31:0] v = 0;
    foreach (dq[i]) v = v * 10 + 32'(dq[i]);
    return v;
  endfunction

  function automatic void fields_clear();
    ph = 0; dq.delete();
    m_acc = 0; m_pin = 0; m_new = 0; m_amt = 0; m_op = 0;
  endfunction

  function automatic void model_reset();
    fields_clear();
    wcnt = 0; m_rs = 0; m_rb = 0; m_to = 0;
  endfunction

  function automatic void model_step(input bit kv, input logic [3:0] kc, input bit rdy,
                                     input bit rv, input bit rs, input logic [31:0] rb);
    bit dig = kv && (kc <= 4'd9);
    bit ent = kv && (kc == 4'd10);
    bit can = kv && (kc == 4'd11);
    bit clr = kv && (kc == 4'd12);
    if (can && ph <= 4) begin fields_clear(); return; end
    case (ph)
      0: if (dig) begin m_acc = 32'(kc); ph = 1; end
      1, 4: begin
        if (clr) dq.delete();
        else if (ent) begin
          if (dq.size() == 4) begin
            if (ph == 1) begin m_pin = as_bcd(); ph = 2; end
            else         begin m_new = as_bcd(); ph = 5; end
            dq.delete();
          end
        end else if (dig && dq.size() < 4) dq.push_back(int'(kc));
      end
      2: if (dig) begin
        if (kc == 1)                begin m_op = 1; ph = 5; end
        else if (kc == 2 || kc == 3) begin m_op = 32'(kc); ph = 3; end
        else if (kc == 4)           begin m_op = 4; ph = 4; end
        else if (kc == 5)           fields_clear();
      end
      3: begin
        if (clr) dq.delete();
        else if (ent) begin
          if (as_dec() != 0) begin m_amt = as_dec(); ph = 5; dq.delete(); end
        end else if (dig && dq.size() < AD) dq.push_back(int'(kc));
      end
      5: if (rdy) begin ph = 6; wcnt = 0; m_to = 0; end
      6: begin
        wcnt++;
        if (rv) begin m_rs = rs; m_rb = rb; ph = 7; end
        else if (wcnt == TO) begin m_to = 1; m_rs = 0; ph = 7; end
      end
      default: fields_clear();
    endcase
  endfunction

  always @(negedge clk) begin
    chk("req_valid",      32'(req_valid),      32'(ph == 5));
    chk("busy",           32'(busy),           32'(ph == 5 || ph == 6));
    chk("result_valid",   32'(result_valid),   32'(ph == 7));
    chk("timeout_err",    32'(timeout_err),    32'(m_to));
    chk("result_success", 32'(result_success), 32'(m_rs));
    chk("result_balance", result_balance,      m_rb);
    if (ph == 5) begin
      chk("req_operation", 32'(req_operation), m_op);
      chk("req_acc_num",   32'(req_acc_num),   m_acc);
      chk("req_pin",       32'(req_pin),       m_pin);
      chk("req_new_pin",   32'(req_new_pin),   m_new);
      chk("req_amount",    req_amount,         m_amt);
    end
  end

  task automatic step(input bit kv, input logic [3:0] kc, input bit rdy,
                      input bit rv, input bit rs, input logic [31:0] rb);
    key_valid = kv; key_code = kc; req_ready = rdy;
    rsp_valid = rv; rsp_success = rs; rsp_balance = rb;
    @(posedge clk);
    model_step(kv, kc, rdy, rv, rs, rb);
    #1;
    key_valid = 1'b0; req_ready = 1'b0; rsp_valid = 1'b0;
  endtask

  task automatic key(input int k);
    step(1'b1, 4'(k), 1'b0, 1'b0, 1'b0, 32'd0);
  endtask

  task automatic keys(input int ks[$]);
    foreach (ks[i]) key(ks[i]);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 32'd0);
  endtask

  task automatic hold_reset();
    key_valid = 1'b0; req_ready = 1'b0; rsp_valid = 1'b0;
    rst = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_valid", 32'(req_valid), 32'd0);
    chk("rst_busy",      32'(busy),      32'd0);
    chk("rst_amount",    req_amount,     32'd0);
    rst = 1'b1;

    // Balance enquiry
    keys('{3, 1, 2, 3, 4, 10, 1});
    chk("s1_req_valid", 32'(req_valid), 32'd1);
    chk("s1_op",        32'(req_operation), 32'd1);
    chk("s1_acc",       32'(req_acc_num), 32'd3);
    chk("s1_pin",       32'(req_pin), 32'h1234);
    chk("s1_amount",    req_amount, 32'd0);
    step(0, 0, 1, 0, 0, 0);
    chk("s1_after_hs",  32'(req_valid), 32'd0);
    step(0, 0, 0, 1, 1, 500);
    chk("s1_result_valid", 32'(result_valid), 32'd1);
    chk("s1_balance",      result_balance, 32'd500);
    chk("s1_success",      32'(result_success), 32'd1);
    idle(1);
    chk("s1_pulse_end", 32'(result_valid), 32'd0);

    // Withdraw 150 with a stalled core
    keys('{0, 9, 9, 9, 9, 10, 2, 1, 5, 0, 10});
    for (int i = 0; i < 5; i++) begin
      chk("s2_hold_valid",  32'(req_valid), 32'd1);
      chk("s2_hold_amount", req_amount, 32'd150);
      chk("s2_hold_pin",    32'(req_pin), 32'h9999);
      idle(1);
    end
    step(0, 0, 1, 0, 0, 0);
    chk("s2_amount_after_hs", req_amount, 32'd150);
    step(0, 0, 0, 1, 0, 77);
    idle(1);

    // Short PIN ENTER ignored, extra PIN digits dropped, change PIN
    keys('{5, 1, 2, 3, 10});
    chk("s3_short_pin", 32'(busy), 32'd0);
    keys('{4, 5, 6, 10, 4, 8, 7, 6, 5, 10});
    chk("s3_pin",     32'(req_pin), 32'h1234);
    chk("s3_new_pin", 32'(req_new_pin), 32'h8765);
    chk("s3_op",      32'(req_operation), 32'd4);
    step(0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 1, 1, 9);
    idle(1);

    // CANCEL in AMOUNT aborts; CANCEL in WAIT_RSP is ignored
    keys('{2, 1, 1, 1, 1, 10, 3, 7, 11});
    idle(2);
    chk("s4_cancel_busy", 32'(busy), 32'd0);
    keys('{2, 1, 1, 1, 1, 10, 1});
    step(0, 0, 1, 0, 0, 0);
    key(11);
    chk("s4_wait_busy", 32'(busy), 32'd1);
    step(0, 0, 0, 1, 1, 1234);
    chk("s4_result", result_balance, 32'd1234);
    idle(1);

    // Amount saturates at AD digits; CLEAR restarts it
    keys('{4, 0, 0, 0, 0, 10, 3, 5, 12, 9, 9, 9, 9, 9, 9, 9, 9, 9, 10});
    chk("s7_amount", req_amount, 32'd99999999);
    step(0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 1, 1, 321);
    idle(1);

    // Timeout, then a response on the final cycle beats the timeout
    keys('{6, 2, 2, 2, 2, 10, 1});
    step(0, 0, 1, 0, 0, 0);
    idle(TO - 1);
    chk("s5_not_yet", 32'(result_valid), 32'd0);
    idle(1);
    chk("s5_to_pulse",   32'(result_valid), 32'd1);
    chk("s5_to_err",     32'(timeout_err), 32'd1);
    chk("s5_to_success", 32'(result_success), 32'd0);
    chk("s5_to_balance", result_balance, 32'd321);
    idle(1);
    keys('{6, 2, 2, 2, 2, 10, 1});
    chk("s5_err_held", 32'(timeout_err), 32'd1);
    step(0, 0, 1, 0, 0, 0);
    chk("s5_err_cleared", 32'(timeout_err), 32'd0);
    idle(TO - 1);
    step(0, 0, 0, 1, 1, 42);
    chk("s5_rsp_wins",     32'(timeout_err), 32'd0);
    chk("s5_rsp_wins_bal", result_balance, 32'd42);
    idle(1);

    // Reset mid-WAIT_RSP
    keys('{7, 3, 3, 3, 3, 10, 1});
    step(0, 0, 1, 0, 0, 0);
    idle(3);
    rst = 1'b0;
    model_reset();
    #1;
    chk("s6_busy",    32'(busy), 32'd0);
    chk("s6_req_pin", 32'(req_pin), 32'd0);
    chk("s6_balance", result_balance, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    step(0, 0, 0, 1, 1, 123);
    chk("s6_no_result", 32'(result_valid), 32'd0);

    // Random traffic
    for (int i = 0; i < 6000; i++) begin
      int r;
      logic [3:0] kc;
      r = $urandom_range(0, 19);
      if (r < 10)      kc = 4'(r);
      else if (r < 14) kc = 4'd10;
      else if (r < 17) kc = 4'(r - 3);
      else             kc = 4'(13 + (r - 17));
      step(bit'($urandom_range(0, 1)), kc, bit'($urandom_range(0, 2) != 0),
           bit'($urandom_range(0, 15) == 0), bit'($urandom_range(0, 1)), $urandom);
      if ($urandom_range(0, 999) == 0) hold_reset();
    end

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
